// File: rtl/ext_irq_controller.sv
// ext_irq_controller: collects edge-triggered interrupt sources and presents
// one request at a time to processor_arm over the ExtIRQ/ExtIAck handshake.
// Rising edges on enabled sources set pending bits. The lowest enabled
// pending index wins. A quiet gap is enforced after each completed handshake.
//
// Handshake: ExtIRQ rises (registered) with irq_id valid and stable. It stays
// high until ExtIAck is sampled high on a rising edge. That edge retires the
// request and drops ExtIRQ. The controller then waits for ExtIAck to return
// low before counting the gap. ExtIAck outside a request is ignored.
module ext_irq_controller #(
    parameter int               N_SRC    = 4,
    parameter int               ID_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    parameter int               MIN_GAP  = 2,
    parameter logic [N_SRC-1:0] MASK_RST = '1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             ExtIAck,
    output logic             ExtIRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic             irq_active,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKD = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // The counter only ever holds MIN_GAP-1 down to 0.
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    state_e             state_q, state_d;
    logic [N_SRC-1:0]   prev_q, prev_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               ext_irq_q, ext_irq_d;

    logic [N_SRC-1:0]   sel;
    logic               sel_any;
    logic [ID_W-1:0]    winner;
    logic [N_SRC-1:0]   clr;
    logic [N_SRC-1:0]   rise;

    // Fixed priority: scan from the top so the lowest set index is left last.
    always_comb begin
        sel     = pending_q & mask_q;
        sel_any = |sel;
        winner  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (sel[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Request FSM: issue, wait for ack, wait for ack release, then quiet gap.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        irq_id_d  = irq_id_q;
        ext_irq_d = ext_irq_q;
        clr       = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    state_d   = ST_REQ;
                    irq_id_d  = winner;
                    ext_irq_d = 1'b1;
                end
            end
            ST_REQ: begin
                ext_irq_d = 1'b1;
                if (ExtIAck) begin
                    for (int i = 0; i < N_SRC; i++) begin
                        clr[i] = (irq_id_q == ID_W'(i));
                    end
                    ext_irq_d = 1'b0;
                    state_d   = ST_ACKD;
                end
            end
            ST_ACKD: begin
                ext_irq_d = 1'b0;
                if (!ExtIAck) begin
                    if (MIN_GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                ext_irq_d = 1'b0;
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ext_irq_d = 1'b0;
            end
        endcase
    end

    // Edge detect, pending latch (a set wins over a same-edge clear), mask write.
    always_comb begin
        prev_d    = irq_src;
        rise      = irq_src & ~prev_q;
        pending_d = (pending_q & ~clr) | (rise & mask_q);
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    // State register for every flop in the block.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
            gap_q     <= '0;
            irq_id_q  <= '0;
            ext_irq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gap_q     <= gap_d;
            irq_id_q  <= irq_id_d;
            ext_irq_q <= ext_irq_d;
        end
    end

    assign ExtIRQ     = ext_irq_q;
    assign irq_id     = irq_id_q;
    assign irq_active = (state_q == ST_REQ) || (state_q == ST_ACKD);
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/ext_irq_controller.md
Name: ext_irq_controller

Overview:
- Interrupt-source side of the ExtIRQ/ExtIAck handshake into processor_arm.
- Collects N_SRC interrupt lines: rising-edge detect, per-source mask, pending latch.
- Fixed priority selects one source, asserts ExtIRQ and holds it until the core returns ExtIAck.
- Exposes the serviced source ID and enforces a minimum quiet gap between successive requests.

Parameters:
- N_SRC, 4, number of interrupt source lines (1..16).
- ID_W, $clog2(N_SRC) (minimum 1), width of irq_id.
- MIN_GAP, 2, idle cycles forced after each completed handshake before the next ExtIRQ (0 = no gap).
- MASK_RST, all ones, reset value of the mask register (1 = enabled).

Ports:
- CLOCK_50  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_src  in  N_SRC  interrupt request lines, synchronous to CLOCK_50, edge-sensitive.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  N_SRC  new mask value; bit i = 1 enables source i.
- ExtIAck  in  1  acknowledge from processor_arm.
- ExtIRQ  out  1  interrupt request to processor_arm (registered).
- irq_id  out  ID_W  index of the source being or last serviced (registered).
- irq_active  out  1  high while in REQ or ACKD.
- pending  out  N_SRC  current pending register.
- mask  out  N_SRC  current mask register.

Behaviour:
- Reset (reset=0, asynchronous):
  - ExtIRQ=0, irq_id=0, irq_active=0, pending=0, mask=MASK_RST.
  - Edge-history register = 0; gap counter = 0; state = IDLE.
  - Reset mid-handshake aborts the handshake; the pending bit is lost.
- Edge detect: at each edge, prev <= irq_src. Rise at edge t means irq_src[i]=1 and prev[i]=0.
- Pending update: a rise at edge t with mask[i]=1 sets pending[i] at edge t.
  - Rises on masked sources are discarded and are not latched later.
- Mask write: mask_we=1 loads mask at the edge.
  - The new mask applies to rises from the following edge onward.
  - Masking a source does not clear its pending bit; a masked pending source is not selectable.
- Selection: lowest index among (pending & mask) wins.
- FSM (states and transitions):
  - IDLE: if (pending & mask) != 0, go to REQ at the next edge, latch irq_id = winner, ExtIRQ <= 1.
  - REQ: ExtIRQ held at 1. On ExtIAck=1, clear pending[irq_id], ExtIRQ <= 0, go to ACKD.
    - Unmasking or masking during REQ does not change irq_id; the request completes.
    - If a new rise on the same source coincides with the clear, set wins: the bit stays 1.
  - ACKD: wait for ExtIAck=0. Then load the gap counter with MIN_GAP-1 and go to GAP; if MIN_GAP=0, go directly to IDLE.
  - GAP: decrement each cycle; when the counter is 0, go to IDLE. New rises still latch into pending.
- Latency (no gap active): source sampled high at edge t, pending visible after t, ExtIRQ high after edge t+1.
- ExtIAck timing:
  - ExtIAck seen at edge u drops ExtIRQ after edge u.
  - ExtIAck already high when entering REQ is accepted on the first REQ edge.
  - ExtIAck in IDLE or GAP is ignored.
- irq_id holds its value outside REQ/ACKD. irq_active = (state==REQ or state==ACKD).
- No overflow conditions exist; a repeated rise while a bit is already pending is merged.

Test Plan:
- Single source: reset released, irq_src=4'b0100 pulse of 1 cycle → pending=4'b0100 after 1 edge, ExtIRQ=1 and irq_id=2 one edge later. ExtIAck high 1 cycle → ExtIRQ=0, pending=0, next ExtIRQ not before MIN_GAP=2 idle cycles.
- Priority: irq_src 4'b1010 rises in the same cycle → first request irq_id=1. After its handshake and gap, second request irq_id=3; pending ends at 0.
- Masking: mask_wdata=4'b1110 written, then rise on source 0 → pending stays 0, ExtIRQ stays 0. Source 0 level held high and then unmasked → still no request, because a new edge is required.
- Set/clear collision: source 1 re-rises on the same edge that ExtIAck clears it → pending[1]=1 remains, second request issued with irq_id=1 after the gap.
- Ack hold: ExtIAck held high 5 cycles → state stays ACKD, ExtIRQ=0 and irq_active=1 throughout. Gap counting begins only after ExtIAck falls.
- Async reset mid-REQ: reset driven low between clock edges while ExtIRQ=1 → ExtIRQ, pending and irq_active go to 0 immediately, mask returns to 4'b1111.
